// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead byte FIFO, valid/ready read side
// and a level interrupt that follows rx_valid.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              clk_div,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_m;
  logic             rx_s;
  logic             rx_p;

  logic [1:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] half_term;
  logic [DIV_W-1:0] bit_term;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             stop_hit;
  logic             do_push;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  // rx_m/rx_s form the synchroniser; rx_p keeps the previous rx_s for edge detection
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_comb begin
    div_eff = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
  end

  assign half_term = (div_q >> 1) - DIV_W'(1);
  assign bit_term  = div_q - DIV_W'(1);
  assign stop_hit  = (state == S_STOP) && (cnt == bit_term);
  assign do_push   = stop_hit && rx_s;

  // div_q is captured only at start detection so a frame in flight keeps its timing
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_q   <= DIV_W'(4);
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_p && !rx_s) begin
            cnt   <= '0;
            div_q <= div_eff;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == half_term) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == bit_term) begin
            cnt           <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == bit_term) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read side: rx_valid means the head byte is on rx_data; a byte is consumed
  // on every rising edge where rx_valid && rx_ready, and rx_ready is ignored when empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign push_ok = do_push && (!full || pop);

  // When full with a simultaneous pop, the written slot is the one being popped
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit && !rx_s;
      overrun   <= do_push && full && !pop;
    end
  end

  assign rx_data    = mem[rd_ptr[AW-1:0]];
  assign rx_valid   = !empty;
  assign irq        = !empty;
  assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- User-project UART receiver; deserialises the host/testbench serial stream arriving on mprj_io[5] (8N1, LSB first).
- Buffers received bytes in a small show-ahead FIFO and presents them over a valid/ready interface to the firmware-facing register/Wishbone logic.
- Raises a level interrupt to the management core while data is pending.
- Direct consumer of the byte stream that the testbench UART transmitter produces.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of 2, minimum 2.
- DIV_W, 16, width of the clk_div input.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  asynchronous, active-low reset.
- rx_i  input  1  raw serial line (from mprj_io[5]); asynchronous to clock; idles high.
- clk_div  input  DIV_W  clock cycles per bit; values below 4 are treated as 4.
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head byte when rx_valid && rx_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- irq  output  1  equals rx_valid (level).

Behaviour:
- Reset values: all outputs 0, including rx_data=0x00. Synchroniser flops = 1, FSM in IDLE, FIFO empty.
- Synchroniser: 2 flops on rx_i, producing rx_s. A third flop rx_p holds the previous rx_s for edge detection.
- Divisor: clk_div is latched into div_q on start detection and stays stable for the whole frame. Mid-frame changes to clk_div have no effect on the frame in progress.
- FSM states:
  - IDLE: on falling edge (rx_p=1, rx_s=0), set cnt=0, latch div_q, go to START.
  - START: count to div_q/2 - 1 (integer divide). At terminal count, if rx_s=0 go to DATA (cnt=0, bit_idx=0); else go to IDLE (glitch rejected, no pulse).
  - DATA: count to div_q - 1, then sample rx_s into shift[bit_idx], LSB first. After bit_idx=7 go to STOP; otherwise bit_idx+1.
  - STOP: count to div_q - 1, then sample rx_s.
    - If 1: push shift into the FIFO.
    - If 0: pulse frame_err; the byte is discarded.
    - Either way go to IDLE. Because IDLE requires a falling edge, a held break (line stuck low) does not retrigger.
- Push timing: the push is registered in the cycle after the stop sample. rx_valid and fifo_level update in that same cycle.
- FIFO (show-ahead): rx_data is driven combinationally from mem[rd_ptr]. Pointers are DEPTH-wrapping with an extra wrap bit for full/empty.
- Pop: occurs on rx_valid && rx_ready; rx_ready is ignored when empty.
- Push+pop in the same cycle when full: both execute, level unchanged, no overrun.
- Push when full without a pop: byte dropped, overrun pulses for 1 cycle, FIFO contents and order unchanged.
- Push+pop in the same cycle when empty: not possible, since rx_valid=0.
- fifo_level range is 0..FIFO_DEPTH, never wraps.
- Reset mid-frame: FSM returns to IDLE and the FIFO is emptied immediately (asynchronous). A partial frame is never pushed. Reception restarts only on the next falling edge after reset release.

Test Plan:
- Reset, then with clk_div=16 send 0x3D, 8N1 -> exactly one push. rx_valid rises within 9.5*16+4 cycles of the start edge; rx_data=0x3D, fifo_level=1, irq=1. Pulse rx_ready for 1 cycle -> rx_valid=0, level=0.
- rx_ready=0, send 0x01..0x05 back-to-back, FIFO_DEPTH=4 -> level reaches 4; overrun pulses once, during the 5th byte's push cycle. Draining yields 0x01, 0x02, 0x03, 0x04 in order.
- Frame with stop bit forced 0 (data 0xA5) -> frame_err pulses 1 cycle, level unchanged, no overrun. The next valid byte 0x5A is received correctly.
- 3-cycle low glitch on rx_i with clk_div=16 -> FSM returns to IDLE, no push, no frame_err.
- FIFO full (0x10..0x13) with rx_ready held 1 during the push of 0x14 -> 0x10 popped, 0x14 enters, no overrun, level stays 4. Drain order 0x11..0x14.
- Assert resetb low mid-DATA (bit 4 of 0x3D) with 2 bytes buffered -> outputs are 0 immediately. After release, a fresh 0x3D is received as the only byte.
- clk_div=2 -> behaves as clk_div=4: 0xC3 is received correctly at 4 cycles/bit.
